// File: rtl/video_fetcher_if.sv
// Wishbone classic read-only bus between the playfield fetcher (master) and video memory (slave).
interface video_fetcher_if #(
  parameter int AW = 23
);
  logic          CYC_O;
  logic          STB_O;
  logic [AW-1:0] ADR_O;
  logic [15:0]   DAT_I;
  logic          ACK_I;

  modport master (output CYC_O, STB_O, ADR_O, input DAT_I, ACK_I);
  modport slave  (input CYC_O, STB_O, ADR_O, output DAT_I, ACK_I);
endinterface

// File: rtl/video_fetcher.sv
// Per-scanline playfield DMA: reads one line of halfwords over Wishbone into the line buffer store port.
//   state   | meaning
//   IDLE    | waiting for HSYNC_I, tracking VSYNC_I into the line pointer
//   FETCH   | bus cycle open, storing each acknowledged halfword
//   RESTART | one dead cycle after an aborting HSYNC_I, then starts the captured line
module video_fetcher #(
  parameter int AW = 23
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             VSYNC_I,
  input  logic             HSYNC_I,
  input  logic             FETCH_EN_I,
  input  logic [AW-1:0]    FB_BASE_I,
  input  logic [9:0]       LINE_LEN_I,
  video_fetcher_if.master  wb,
  output logic [8:0]       S_ADR_O,
  output logic [15:0]      S_DAT_O,
  output logic             S_WE_O,
  output logic             BUSY_O,
  output logic             UNDERRUN_O
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RESTART = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] lp_q, lp_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [9:0]    len_q, len_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [9:0]    rlen_q, rlen_d;
  logic          ren_q, ren_d;
  logic          cyc_q, cyc_d;
  logic          swe_q, swe_d;
  logic [8:0]    sadr_q, sadr_d;
  logic [15:0]   sdat_q, sdat_d;
  logic          und_q, und_d;

  logic [9:0]    len_in;
  logic [AW-1:0] len_ext;
  logic          ack;
  logic          last;
  logic          start_req;
  logic [9:0]    start_len;

  assign len_in  = (LINE_LEN_I > 10'd512) ? 10'd512 : LINE_LEN_I;
  assign len_ext = {{(AW-10){1'b0}}, len_q};
  assign ack     = wb.ACK_I & cyc_q;
  assign last    = (cnt_q == len_q - 10'd1);

  always_comb begin
    state_d   = state_q;
    lp_d      = lp_q;
    adr_d     = adr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rlen_d    = rlen_q;
    ren_d     = ren_q;
    cyc_d     = cyc_q;
    swe_d     = 1'b0;
    sadr_d    = sadr_q;
    sdat_d    = sdat_q;
    und_d     = 1'b0;
    start_req = 1'b0;
    start_len = len_in;

    case (state_q)
      IDLE, RESTART: begin
        // RESTART replays the HSYNC that aborted the previous line with its captured settings
        if (state_q == RESTART) begin
          start_req = ren_q && (rlen_q != 10'd0);
          start_len = rlen_q;
        end else begin
          start_req = HSYNC_I && FETCH_EN_I && (len_in != 10'd0);
        end
        if (VSYNC_I) lp_d = FB_BASE_I;
        if (start_req) begin
          len_d   = start_len;
          adr_d   = VSYNC_I ? FB_BASE_I : lp_q;
          cnt_d   = 10'd0;
          cyc_d   = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (ack) begin
          swe_d  = 1'b1;
          sadr_d = cnt_q[8:0];
          sdat_d = wb.DAT_I;
          adr_d  = adr_q + 1'b1;
          cnt_d  = cnt_q + 10'd1;
        end
        if (VSYNC_I) begin
          cyc_d   = 1'b0;
          lp_d    = FB_BASE_I;
          rlen_d  = len_in;
          ren_d   = FETCH_EN_I;
          state_d = HSYNC_I ? RESTART : IDLE;
        end else if (HSYNC_I) begin
          // lp still advances by the full line so the frame geometry survives an underrun
          cyc_d   = 1'b0;
          und_d   = !(ack && last);
          lp_d    = lp_q + len_ext;
          rlen_d  = len_in;
          ren_d   = FETCH_EN_I;
          state_d = RESTART;
        end else if (ack && last) begin
          cyc_d   = 1'b0;
          lp_d    = lp_q + len_ext;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      lp_q    <= '0;
      adr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rlen_q  <= '0;
      ren_q   <= 1'b0;
      cyc_q   <= 1'b0;
      swe_q   <= 1'b0;
      sadr_q  <= '0;
      sdat_q  <= '0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rlen_q  <= rlen_d;
      ren_q   <= ren_d;
      cyc_q   <= cyc_d;
      swe_q   <= swe_d;
      sadr_q  <= sadr_d;
      sdat_q  <= sdat_d;
      und_q   <= und_d;
    end
  end

  assign wb.CYC_O   = cyc_q;
  assign wb.STB_O   = cyc_q;
  assign wb.ADR_O   = adr_q;
  assign S_WE_O     = swe_q;
  assign S_ADR_O    = sadr_q;
  assign S_DAT_O    = sdat_q;
  assign UNDERRUN_O = und_q;
  assign BUSY_O     = (state_q != IDLE);

endmodule

// File: tb/tb_video_fetcher.sv
// Randomized bench for video_fetcher: per-line expectations come from a line-pointer model and a memory function.
module tb_video_fetcher;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync, hsync, fetch_en, ack_en;
  logic [AW-1:0] fb_base;
  logic [9:0]    line_len;
  logic [8:0]    s_adr;
  logic [15:0]   s_dat;
  logic          s_we, busy, underrun;

  int n_chk  = 0;
  int n_pass = 0;

  logic [AW-1:0] mlp;

  video_fetcher_if #(.AW(AW)) bus ();

  video_fetcher #(.AW(AW)) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .VSYNC_I    (vsync),
    .HSYNC_I    (hsync),
    .FETCH_EN_I (fetch_en),
    .FB_BASE_I  (fb_base),
    .LINE_LEN_I (line_len),
    .wb         (bus),
    .S_ADR_O    (s_adr),
    .S_DAT_O    (s_dat),
    .S_WE_O     (s_we),
    .BUSY_O     (busy),
    .UNDERRUN_O (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ {a[22:16], 9'h000} ^ 16'h3C5A;
  endfunction

  assign bus.DAT_I = mem_f(bus.ADR_O);
  assign bus.ACK_I = ack_en;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic frame(input logic [AW-1:0] b);
    @(negedge clk);
    vsync = 1'b1; fb_base = b;
    @(negedge clk);
    vsync = 1'b0;
    mlp = b;
  endtask

  // One scanline. pre=1: the line was armed by the previous call's aborting HSYNC.
  // abort_at>=0: after that many acks, abort with HSYNC (plus VSYNC if abort_vs) carrying nlen/nen.
  task automatic run_line(input bit vs, input int len, input bit en, input bit pre,
                          input int abort_at, input bit abort_vs, input int nlen, input bit nen,
                          input int ack_pct);
    int leff, acks, wr;
    bit pend, done;
    logic [AW-1:0] start;
    leff = (len > 512) ? 512 : len;
    acks = 0; wr = 0; pend = 1'b0; done = 1'b0;
    @(negedge clk);
    if (!pre) begin
      hsync = 1'b1; vsync = vs; line_len = len[9:0]; fetch_en = en; ack_en = 1'b0;
      if (vs) mlp = fb_base;
      @(negedge clk);
      hsync = 1'b0; vsync = 1'b0;
    end
    start = mlp;
    if (!(en && leff != 0)) begin
      for (int i = 0; i < 3; i++) begin
        check_val("idle_cyc", {31'd0, bus.CYC_O}, 32'd0);
        check_val("idle_we", {31'd0, s_we}, 32'd0);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        ack_en = ($urandom_range(1) == 1);
        @(negedge clk);
      end
      ack_en = 1'b0;
      return;
    end
    check_val("start_cyc", {31'd0, bus.CYC_O}, 32'd1);
    for (int c = 0; c < leff * 40 + 20; c++) begin
      check_val("stb_eq_cyc", {31'd0, bus.STB_O}, {31'd0, bus.CYC_O});
      if (pend) begin
        check_val("we", {31'd0, s_we}, 32'd1);
        check_val("s_adr", {23'd0, s_adr}, wr);
        check_val("s_dat", {16'd0, s_dat}, {16'd0, mem_f(start + AW'(wr))});
        wr++;
      end else begin
        check_val("we_quiet", {31'd0, s_we}, 32'd0);
      end
      if (!bus.CYC_O) begin
        done = 1'b1;
        break;
      end
      check_val("adr", {9'd0, bus.ADR_O}, {9'd0, start + AW'(acks)});
      if (abort_at >= 0 && acks == abort_at) begin
        hsync = 1'b1; vsync = abort_vs; line_len = nlen[9:0]; fetch_en = nen; ack_en = 1'b0;
        @(negedge clk);
        hsync = 1'b0; vsync = 1'b0;
        check_val("abort_cyc", {31'd0, bus.CYC_O}, 32'd0);
        check_val("abort_we", {31'd0, s_we}, 32'd0);
        check_val("underrun", {31'd0, underrun}, {31'd0, !abort_vs});
        mlp = abort_vs ? fb_base : mlp + AW'(leff);
        return;
      end
      ack_en = ($urandom_range(99) < ack_pct);
      pend = ack_en;
      if (pend) acks++;
      @(negedge clk);
    end
    ack_en = 1'b0;
    if (!done) check_val("line_timeout", 32'd0, 32'd1);
    check_val("wr_count", wr, leff);
    check_val("end_underrun", {31'd0, underrun}, 32'd0);
    check_val("end_busy", {31'd0, busy}, 32'd0);
    mlp = mlp + AW'(leff);
  endtask

  initial begin
    int len, nlen, abort_at;
    bit en, nen, vs, avs;
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; fetch_en = 1'b0; ack_en = 1'b0;
    fb_base = '0; line_len = '0; mlp = '0;
    repeat (3) @(negedge clk);
    check_val("rst_cyc", {31'd0, bus.CYC_O}, 32'd0);
    check_val("rst_stb", {31'd0, bus.STB_O}, 32'd0);
    check_val("rst_adr", {9'd0, bus.ADR_O}, 32'd0);
    check_val("rst_we", {31'd0, s_we}, 32'd0);
    check_val("rst_sadr", {23'd0, s_adr}, 32'd0);
    check_val("rst_sdat", {16'd0, s_dat}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0;

    frame(23'h001000);
    run_line(0, 4, 1, 0, -1, 0, 0, 0, 100);
    run_line(0, 4, 1, 0, -1, 0, 0, 0, 100);
    run_line(0, 3, 1, 0, -1, 0, 0, 0, 34);
    run_line(0, 8, 1, 0, 2, 0, 8, 1, 100);
    run_line(0, 8, 1, 1, -1, 0, 0, 0, 100);
    frame(23'h002000);
    run_line(0, 10, 1, 0, 3, 0, 5, 1, 100);
    run_line(0, 5, 1, 1, -1, 0, 0, 0, 60);
    fb_base = 23'h001000;
    run_line(0, 6, 1, 0, 1, 1, 4, 1, 100);
    run_line(0, 4, 1, 1, -1, 0, 0, 0, 100);
    run_line(0, 7, 0, 0, -1, 0, 0, 0, 100);
    run_line(0, 0, 1, 0, -1, 0, 0, 0, 100);
    run_line(0, 2, 1, 0, -1, 0, 0, 0, 100);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(9) == 0) frame(AW'($urandom));
      vs  = ($urandom_range(9) == 0);
      len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(40, 1));
      en  = ($urandom_range(9) != 0);
      if (en && len > 0 && $urandom_range(3) == 0) begin
        abort_at = int'($urandom_range(len - 1));
        nlen = int'($urandom_range(20));
        nen  = ($urandom_range(3) != 0);
        avs  = ($urandom_range(3) == 0);
        run_line(vs, len, en, 0, abort_at, avs, nlen, nen, int'($urandom_range(100, 25)));
        run_line(0, nlen, nen, 1, -1, 0, 0, 0, int'($urandom_range(100, 25)));
      end else begin
        run_line(vs, len, en, 0, -1, 0, 0, 0, int'($urandom_range(100, 25)));
      end
    end

    frame(23'h7FFFFE);
    run_line(0, 700, 1, 0, -1, 0, 0, 0, 100);
    check_val("wrap_lp", {9'd0, mlp}, 32'h0001FE);
    run_line(0, 3, 1, 0, -1, 0, 0, 0, 100);

    @(negedge clk);
    hsync = 1'b1; line_len = 10'd20; fetch_en = 1'b1; ack_en = 1'b0;
    @(negedge clk);
    hsync = 1'b0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("mrst_cyc", {31'd0, bus.CYC_O}, 32'd0);
    check_val("mrst_we", {31'd0, s_we}, 32'd0);
    check_val("mrst_adr", {9'd0, bus.ADR_O}, 32'd0);
    check_val("mrst_sadr", {23'd0, s_adr}, 32'd0);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; ack_en = 1'b0;
    mlp = '0;
    run_line(0, 5, 1, 0, -1, 0, 0, 0, 100);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
